// File: rtl/m2_stage_pkg.sv
// Shared constants for the M2 memory stage: bus widths and the bit index of
// each memory instruction within the one-hot mem_inst field.
package m2_stage_pkg;

   localparam int M1_TO_MS_BUS_WD = 149;
   localparam int MS_TO_WS_BUS_WD = 73;
   localparam int MEM_INST_WD     = 12;

   // mem_inst is one-hot, bit 0 upward
   localparam int MI_LB  = 0;
   localparam int MI_LBU = 1;
   localparam int MI_LH  = 2;
   localparam int MI_LHU = 3;
   localparam int MI_LW  = 4;
   localparam int MI_LWL = 5;
   localparam int MI_LWR = 6;
   localparam int MI_SB  = 7;
   localparam int MI_SH  = 8;
   localparam int MI_SW  = 9;
   localparam int MI_SWL = 10;
   localparam int MI_SWR = 11;

endpackage

// File: rtl/m2_stage_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the returned load
// word, sign- or zero-extends it, and merges LWL/LWR with the old rt value.
module load_align
   import m2_stage_pkg::*;
(
   input  logic [MEM_INST_WD-1:0] mem_inst,
   input  logic [1:0]             addr,
   input  logic [31:0]            word,
   input  logic [31:0]            rt_value,
   output logic [31:0]            result
);

   logic [7:0]  byte_sel_s;
   logic [15:0] half_sel_s;
   logic [31:0] lwl_s;
   logic [31:0] lwr_s;

   // Select the addressed byte and halfword of the load word
   always_comb begin
      byte_sel_s = word[7:0];
      case (addr)
         2'd0:    byte_sel_s = word[7:0];
         2'd1:    byte_sel_s = word[15:8];
         2'd2:    byte_sel_s = word[23:16];
         2'd3:    byte_sel_s = word[31:24];
         default: byte_sel_s = word[7:0];
      endcase
      if (addr[1]) begin
         half_sel_s = word[31:16];
      end else begin
         half_sel_s = word[15:0];
      end
   end

   // LWL: low bytes of the word fill the register from the top down
   always_comb begin
      lwl_s = word;
      case (addr)
         2'd0:    lwl_s = {word[7:0],  rt_value[23:0]};
         2'd1:    lwl_s = {word[15:0], rt_value[15:0]};
         2'd2:    lwl_s = {word[23:0], rt_value[7:0]};
         2'd3:    lwl_s = word;
         default: lwl_s = word;
      endcase
   end

   // LWR: high bytes of the word fill the register from the bottom up
   always_comb begin
      lwr_s = word;
      case (addr)
         2'd0:    lwr_s = word;
         2'd1:    lwr_s = {rt_value[31:24], word[31:8]};
         2'd2:    lwr_s = {rt_value[31:16], word[31:16]};
         2'd3:    lwr_s = {rt_value[31:8],  word[31:24]};
         default: lwr_s = word;
      endcase
   end

   // Pick the result for whichever load is active; stores carry no load data
   always_comb begin
      result = 32'h0000_0000;
      if (mem_inst[MI_LB]) begin
         result = {{24{byte_sel_s[7]}}, byte_sel_s};
      end else if (mem_inst[MI_LBU]) begin
         result = {24'h00_0000, byte_sel_s};
      end else if (mem_inst[MI_LH]) begin
         result = {{16{half_sel_s[15]}}, half_sel_s};
      end else if (mem_inst[MI_LHU]) begin
         result = {16'h0000, half_sel_s};
      end else if (mem_inst[MI_LW]) begin
         result = word;
      end else if (mem_inst[MI_LWL]) begin
         result = lwl_s;
      end else if (mem_inst[MI_LWR]) begin
         result = lwr_s;
      end else if (|mem_inst[MI_SWR:MI_SB]) begin
         result = 32'h0000_0000;
      end else begin
         result = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/m2_stage.sv
// Second memory stage: holds each instruction from M1 until its load data
// (if any) returns, buffers that data while WB is stalled, and produces the
// register-file write plus forwarding/interlock information for ID.
module m2_stage #(
   parameter int M1_TO_MS_BUS_WD = m2_stage_pkg::M1_TO_MS_BUS_WD,
   parameter int MS_TO_WS_BUS_WD = m2_stage_pkg::MS_TO_WS_BUS_WD
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       m1s_to_ms_valid,
   input  logic [M1_TO_MS_BUS_WD-1:0] m1s_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_data_ok,
   input  logic [31:0]                data_rdata,
   output logic [4:0]                 Ms_dest,
   output logic [31:0]                Ms_result,
   output logic                       ms_load_pending
);

   import m2_stage_pkg::*;

   logic                       ms_valid_r;
   logic [M1_TO_MS_BUS_WD-1:0] bus_r;
   logic [31:0]                rdata_buf_r;
   logic                       rdata_buf_vld_r;

   logic                   mfc0_s;
   logic [31:0]            cp0_data_s;
   logic                   ex_s;
   logic [31:0]            rt_value_s;
   logic [MEM_INST_WD-1:0] mem_inst_s;
   logic                   res_from_mem_s;
   logic                   gr_we_s;
   logic [4:0]             dest_s;
   logic [31:0]            alu_result_s;
   logic [31:0]            pc_s;

   logic        ms_wait_s;
   logic        ms_ready_go_s;
   logic [31:0] load_word_s;
   logic [31:0] load_result_s;
   logic [31:0] final_result_s;
   logic [3:0]  rf_wen_s;

   // Unpack the captured M1 payload
   assign {mfc0_s, cp0_data_s, ex_s, rt_value_s, mem_inst_s, res_from_mem_s,
           gr_we_s, dest_s, alu_result_s, pc_s} = bus_r;

   // A non-excepting load stalls until data arrives, unless already buffered
   assign ms_wait_s       = ms_valid_r & res_from_mem_s & ~ex_s & ~rdata_buf_vld_r;
   assign ms_ready_go_s   = ~ms_wait_s | data_data_ok;
   assign ms_allowin      = ~ms_valid_r | (ms_ready_go_s & ws_allowin);
   assign ms_to_ws_valid  = ms_valid_r & ms_ready_go_s;
   assign ms_load_pending = ms_wait_s;

   // Buffered data wins once captured so later DCache bus activity is ignored
   assign load_word_s = rdata_buf_vld_r ? rdata_buf_r : data_rdata;

   load_align u_load_align (
      .mem_inst (mem_inst_s),
      .addr     (alu_result_s[1:0]),
      .word     (load_word_s),
      .rt_value (rt_value_s),
      .result   (load_result_s)
   );

   // Choose the value written back: load data, CP0 read, or ALU result
   always_comb begin
      final_result_s = alu_result_s;
      if (res_from_mem_s) begin
         final_result_s = load_result_s;
      end else if (mfc0_s) begin
         final_result_s = cp0_data_s;
      end else begin
         final_result_s = alu_result_s;
      end
   end

   assign rf_wen_s     = {4{gr_we_s & ms_valid_r & ~ex_s}};
   assign ms_to_ws_bus = {rf_wen_s, dest_s, final_result_s, pc_s};
   assign Ms_result    = final_result_s;

   // Forwarding destination is only meaningful for a live register writer
   always_comb begin
      Ms_dest = 5'd0;
      if (ms_valid_r & gr_we_s) begin
         Ms_dest = dest_s;
      end else begin
         Ms_dest = 5'd0;
      end
   end

   // Stage occupancy: refilled whenever the stage can accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ms_valid_r <= 1'b0;
      end else if (ms_allowin) begin
         ms_valid_r <= m1s_to_ms_valid;
      end else begin
         ms_valid_r <= ms_valid_r;
      end
   end

   // Pipeline register: captures the M1 payload on a handshake
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus_r <= '0;
      end else if (ms_allowin & m1s_to_ms_valid) begin
         bus_r <= m1s_to_ms_bus;
      end else begin
         bus_r <= bus_r;
      end
   end

   // Hold returned load data while WB is stalled; release when the load leaves
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf_r     <= 32'h0000_0000;
         rdata_buf_vld_r <= 1'b0;
      end else if (ms_wait_s & data_data_ok & ~ws_allowin) begin
         rdata_buf_r     <= data_rdata;
         rdata_buf_vld_r <= 1'b1;
      end else if (ms_to_ws_valid & ws_allowin) begin
         rdata_buf_r     <= rdata_buf_r;
         rdata_buf_vld_r <= 1'b0;
      end else begin
         rdata_buf_r     <= rdata_buf_r;
         rdata_buf_vld_r <= rdata_buf_vld_r;
      end
   end

endmodule

// File: doc/m2_stage.md
# m2_stage

Second memory stage of the five-plus-stage MIPS pipeline, directly downstream of `m1_stage` and upstream of the write-back stage. It takes instructions out of M1 and waits for the DCache to return load data for any load that M1 issued. It aligns and sign/zero-extends that data, merges LWL/LWR results with the old rt value, and hands the final register-file write to WB. It also drives the M2 forwarding and load-interlock signals back to the ID stage.

## Interface
Parameters:
- `M1_TO_MS_BUS_WD`, default 149: width of the incoming bus. Field order, MSB first:
  - mfc0 (1), cp0_data (32), ex (1), rt_value (32), mem_inst (12), res_from_mem (1), gr_we (1), dest (5), alu_result (32), pc (32).
- `MS_TO_WS_BUS_WD`, default 73: width of the outgoing bus. Field order, MSB first:
  - rf_wen (4), dest (5), final_result (32), pc (32).

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `resetn` in 1: asynchronous active-low reset.
- `ws_allowin` in 1: WB can accept an instruction this cycle.
- `ms_allowin` out 1: M2 can accept an instruction this cycle.
- `m1s_to_ms_valid` in 1: M1 is presenting a valid instruction.
- `m1s_to_ms_bus` in `M1_TO_MS_BUS_WD`: instruction payload from M1.
- `ms_to_ws_valid` out 1: M2 is presenting a valid instruction to WB.
- `ms_to_ws_bus` out `MS_TO_WS_BUS_WD`: payload to WB.
- `data_data_ok` in 1: one-cycle DCache pulse; load data is valid this cycle.
- `data_rdata` in 32: load word returned by the DCache.
- `Ms_dest` out 5: destination register for forwarding. Equals dest when `ms_valid` and gr_we; otherwise 0.
- `Ms_result` out 32: final result for forwarding.
- `ms_load_pending` out 1: M2 holds a load whose data has not arrived yet. ID must stall on a dependency while this is high.

## Operation
- mem_inst is one-hot, bit 0 upward: lb, lbu, lh, lhu, lw, lwl, lwr, sb, sh, sw, swl, swr.
- State is the pipeline register, `ms_valid`, `rdata_buf` (32 bits) and `rdata_buf_vld`.
- `ms_wait = ms_valid & res_from_mem & ~ex & ~rdata_buf_vld`.
- `ms_ready_go = ~ms_wait | data_data_ok`.
- `ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin)`.
- `ms_to_ws_valid = ms_valid & ms_ready_go`.
- The load word comes from `rdata_buf` when `rdata_buf_vld` is set; otherwise it comes from `data_rdata`.
- If `data_data_ok` arrives while `ms_wait` is high and `ws_allowin` is low, the data is captured into `rdata_buf` and `rdata_buf_vld` is set.
- `rdata_buf_vld` clears when the instruction leaves M2.
- A `data_data_ok` that arrives while `ms_wait` is low is discarded.
- Alignment uses a = alu_result[1:0]:
  - lb/lbu select byte a; lh/lhu select the halfword at a[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - lw takes the full word.
- LWL, with W the load word and R = rt_value:
  - a=0: {W[7:0], R[23:0]}
  - a=1: {W[15:0], R[15:0]}
  - a=2: {W[23:0], R[7:0]}
  - a=3: W
- LWR:
  - a=0: W
  - a=1: {R[31:24], W[31:8]}
  - a=2: {R[31:16], W[31:16]}
  - a=3: {R[31:8], W[31:24]}
- `final_result` is the aligned/merged load value if res_from_mem; cp0_data if mfc0; alu_result otherwise.
- `rf_wen = {4{gr_we & ms_valid & ~ex}}`.
- Stores and exception-marked instructions pass through without waiting.

## Timing
- Reset clears `ms_valid`, `rdata_buf_vld`, `rdata_buf` and the pipeline register. Every output is therefore 0 during reset, except `ms_allowin`, which is 1.
- Non-load: one cycle in M2. It is presented in the cycle after capture.
- Load: `ms_to_ws_valid` rises in the same cycle as `data_data_ok`; this path is combinational.
  - If WB is stalled, the load is presented from `rdata_buf` in every later cycle until `ws_allowin`.
- If an instruction leaves and M1 presents a valid one in the same cycle, the new one is captured with no bubble.
- `ms_load_pending` equals `ms_wait`.
- An asynchronous reset in mid-wait discards the pending load. Any late `data_data_ok` is then ignored, because `ms_wait` is low.

## Structure
- A shared include holds:
  - `M1_TO_MS_BUS_WD` and `MS_TO_WS_BUS_WD`.
  - The mem_inst bit-index constants.
- One combinational sub-module, `load_align`, takes (mem_inst, addr[1:0], word, rt_value) and returns the 32-bit result. It is unit-tested standalone.

## Test plan
- lw, alu_result=0x80001004. `data_data_ok` arrives 3 cycles after capture with rdata 0x12345678. `ms_to_ws_valid` is high in that cycle, final_result=0x12345678, rf_wen=4'hf, and `ms_load_pending` was high for the 3 prior cycles.
- lb at addr[1:0]=3 with rdata 0x80FFFFFF gives 0xFFFFFF80. lbu gives 0x00000080. lh at addr[1:0]=2 with rdata 0x8001_0000 gives 0xFFFF8001.
- rt_value=0xAABBCCDD, rdata=0x11223344:
  - lwl at addr[1:0]=1 gives 0x3344CCDD.
  - lwr at addr[1:0]=2 gives 0xAABB1122.
- Load with `ws_allowin` low when `data_data_ok` arrives, rdata 0xCAFEF00D, held low 4 more cycles. The buffered value 0xCAFEF00D is presented, and changes on `data_rdata` in the meantime are ignored.
- An ex=1 load with gr_we=1 leaves in 1 cycle with rf_wen=0 and does not wait for `data_data_ok`.
- Assert `resetn` low during a load wait. All outputs return to reset values, and a `data_data_ok` pulse afterwards produces no `ms_to_ws_valid`.
